// File: rtl/mem_arbiter_if.sv
// Bundle of requester, host and return signals for mem_arbiter.
// Ports: Fe*/Me* requesters, *_host memory side; slave=arbiter, master=env.
interface mem_arbiter_if;
  logic [1:0]   Feop;
  logic [31:0]  FeAddr;
  logic [511:0] FeDataOut;
  logic [511:0] FeDataIn;
  logic         Fetx_done;
  logic         Ferd_valid;

  logic [1:0]   Meop;
  logic [31:0]  MeAddr;
  logic [511:0] MeDataOut;
  logic [511:0] MeDataIn;
  logic         Metx_done;
  logic         Merd_valid;

  logic [1:0]   op_host;
  logic [31:0]  AddrOut_host;
  logic [511:0] DataOut_host;
  logic [511:0] DataIn_host;
  logic         tx_done_host;
  logic         rd_valid_host;

  modport slave (
    input  Feop, FeAddr, FeDataOut,
    output FeDataIn, Fetx_done, Ferd_valid,
    input  Meop, MeAddr, MeDataOut,
    output MeDataIn, Metx_done, Merd_valid,
    output op_host, AddrOut_host, DataOut_host,
    input  DataIn_host, tx_done_host, rd_valid_host
  );

  modport master (
    output Feop, FeAddr, FeDataOut,
    input  FeDataIn, Fetx_done, Ferd_valid,
    output Meop, MeAddr, MeDataOut,
    input  MeDataIn, Metx_done, Merd_valid,
    input  op_host, AddrOut_host, DataOut_host,
    output DataIn_host, tx_done_host, rd_valid_host
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/memory) round-robin arbiter onto one host port.
// Ports: clk, rst (async high), bus (mem_arbiter_if.slave).
module mem_arbiter (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_FE = 2'd1,
    GNT_ME = 2'd2
  } state_t;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  // last_gnt: 0 = fetch served last, 1 = memory served last
  state_t       r_state;
  logic         r_last_gnt;
  logic [1:0]   r_op;
  logic [31:0]  r_addr;
  logic [511:0] r_data;

  logic w_fe_pend;
  logic w_me_pend;
  logic w_pick_fe;
  logic w_rd_ok;
  logic w_gnt_fe;
  logic w_gnt_me;

  assign w_fe_pend = (bus.Feop == OP_READ) ||
                     (bus.Feop == OP_WRITE);
  assign w_me_pend = (bus.Meop == OP_READ) ||
                     (bus.Meop == OP_WRITE);

  // fetch wins when alone, or on a tie when memory went last
  assign w_pick_fe = w_fe_pend &&
                     (!w_me_pend || r_last_gnt);

  // captured registers double as the host outputs; they are
  // cleared on release so the host sees zeros while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_op       <= OP_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_fe) begin
            r_state    <= GNT_FE;
            r_last_gnt <= 1'b0;
            r_op       <= bus.Feop;
            r_addr     <= bus.FeAddr;
            r_data     <= bus.FeDataOut;
          end else if (w_me_pend) begin
            r_state    <= GNT_ME;
            r_last_gnt <= 1'b1;
            r_op       <= bus.Meop;
            r_addr     <= bus.MeAddr;
            r_data     <= bus.MeDataOut;
          end
        end
        GNT_FE, GNT_ME: begin
          if (bus.tx_done_host) begin
            r_state <= IDLE;
            r_op    <= OP_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_op    <= OP_IDLE;
          r_addr  <= '0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign bus.op_host      = r_op;
  assign bus.AddrOut_host = r_addr;
  assign bus.DataOut_host = r_data;

  assign w_gnt_fe = (r_state == GNT_FE);
  assign w_gnt_me = (r_state == GNT_ME);

  // read data only counts during a granted read
  assign w_rd_ok = bus.rd_valid_host && (r_op == OP_READ);

  always_comb begin
    bus.Fetx_done  = 1'b0;
    bus.Ferd_valid = 1'b0;
    bus.FeDataIn   = '0;
    bus.Metx_done  = 1'b0;
    bus.Merd_valid = 1'b0;
    bus.MeDataIn   = '0;
    if (w_gnt_fe) begin
      bus.Fetx_done  = bus.tx_done_host;
      bus.Ferd_valid = w_rd_ok;
      if (w_rd_ok) bus.FeDataIn = bus.DataIn_host;
    end
    if (w_gnt_me) begin
      bus.Metx_done  = bus.tx_done_host;
      bus.Merd_valid = w_rd_ok;
      if (w_rd_ok) bus.MeDataIn = bus.DataIn_host;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter.
// Table of per-cycle stimulus/expectations plus reset-mid-op sequence.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [511:0] D_A5 = {64{8'hA5}};
  localparam logic [511:0] D_FE = {16{32'hF0F0_0001}};
  localparam logic [511:0] D_ME = {16{32'h0E0E_0002}};

  typedef struct {
    logic [1:0]  feop;
    logic [31:0] feaddr;
    logic [1:0]  meop;
    logic [31:0] meaddr;
    logic        txd;
    logic        rdv;
    logic [1:0]  eop;
    logic [31:0] eaddr;
    int          edsel;
    logic        efd;
    logic        efv;
    logic        emd;
    logic        emv;
  } vec_t;

  int errors = 0;
  int checks = 0;

  vec_t vecs[18];

  function automatic vec_t v(
    input logic [1:0] feop, input logic [31:0] feaddr,
    input logic [1:0] meop, input logic [31:0] meaddr,
    input logic txd, input logic rdv,
    input logic [1:0] eop, input logic [31:0] eaddr,
    input int edsel,
    input logic efd, input logic efv,
    input logic emd, input logic emv);
    vec_t r;
    r.feop = feop; r.feaddr = feaddr;
    r.meop = meop; r.meaddr = meaddr;
    r.txd = txd; r.rdv = rdv;
    r.eop = eop; r.eaddr = eaddr; r.edsel = edsel;
    r.efd = efd; r.efv = efv; r.emd = emd; r.emv = emv;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] eop,
                         input logic [31:0] eaddr,
                         input logic [511:0] edata,
                         input logic efd, input logic efv,
                         input logic emd, input logic emv);
    chk({tag, " op_host"}, 512'(bus.op_host), 512'(eop));
    chk({tag, " addr"}, 512'(bus.AddrOut_host), 512'(eaddr));
    chk({tag, " dout"}, bus.DataOut_host, edata);
    chk({tag, " Fetx_done"}, 512'(bus.Fetx_done), 512'(efd));
    chk({tag, " Ferd_valid"}, 512'(bus.Ferd_valid), 512'(efv));
    chk({tag, " FeDataIn"}, bus.FeDataIn, efv ? D_A5 : '0);
    chk({tag, " Metx_done"}, 512'(bus.Metx_done), 512'(emd));
    chk({tag, " Merd_valid"}, 512'(bus.Merd_valid), 512'(emv));
    chk({tag, " MeDataIn"}, bus.MeDataIn, emv ? D_A5 : '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // row k: inputs held in cycle k, outputs checked in cycle k
    vecs[0]  = v(2'b01, 32'h1000, 2'b10, 32'h2000, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[1]  = v(2'b01, 32'h1000, 2'b10, 32'h2000, 0, 0,
                 2'b01, 32'h1000, 1, 0, 0, 0, 0);
    vecs[2]  = v(2'b01, 32'h1000, 2'b10, 32'h2000, 0, 0,
                 2'b01, 32'h1000, 1, 0, 0, 0, 0);
    vecs[3]  = v(2'b01, 32'h1000, 2'b10, 32'h2000, 1, 1,
                 2'b01, 32'h1000, 1, 1, 1, 0, 0);
    vecs[4]  = v(2'b00, 32'h1000, 2'b10, 32'h2000, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[5]  = v(2'b00, 32'h0, 2'b10, 32'h3000, 0, 1,
                 2'b10, 32'h2000, 2, 0, 0, 0, 0);
    vecs[6]  = v(2'b00, 32'h0, 2'b10, 32'h3000, 1, 1,
                 2'b10, 32'h2000, 2, 0, 0, 1, 0);
    vecs[7]  = v(2'b00, 32'h0, 2'b00, 32'h0, 1, 1,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[8]  = v(2'b00, 32'h0, 2'b00, 32'h0, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[9]  = v(2'b01, 32'h10, 2'b01, 32'h20, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[10] = v(2'b01, 32'h10, 2'b01, 32'h20, 1, 1,
                 2'b01, 32'h10, 1, 1, 1, 0, 0);
    vecs[11] = v(2'b01, 32'h10, 2'b01, 32'h20, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[12] = v(2'b01, 32'h10, 2'b01, 32'h20, 1, 1,
                 2'b01, 32'h20, 2, 0, 0, 1, 1);
    vecs[13] = v(2'b01, 32'h10, 2'b01, 32'h20, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[14] = v(2'b01, 32'h10, 2'b01, 32'h20, 1, 1,
                 2'b01, 32'h10, 1, 1, 1, 0, 0);
    vecs[15] = v(2'b01, 32'h10, 2'b01, 32'h20, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);
    vecs[16] = v(2'b01, 32'h10, 2'b01, 32'h20, 1, 1,
                 2'b01, 32'h20, 2, 0, 0, 1, 1);
    vecs[17] = v(2'b00, 32'h0, 2'b00, 32'h0, 0, 0,
                 2'b00, 32'h0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    bus.Feop = 2'b00;
    bus.FeAddr = '0;
    bus.FeDataOut = D_FE;
    bus.Meop = 2'b00;
    bus.MeAddr = '0;
    bus.MeDataOut = D_ME;
    bus.DataIn_host = D_A5;
    bus.tx_done_host = 1'b0;
    bus.rd_valid_host = 1'b0;

    #3;
    chk_all("reset", 2'b00, 32'h0, '0, 0, 0, 0, 0);
    #4;
    rst = 1'b0;

    foreach (vecs[i]) begin
      logic [511:0] ed;
      bus.Feop = vecs[i].feop;
      bus.FeAddr = vecs[i].feaddr;
      bus.Meop = vecs[i].meop;
      bus.MeAddr = vecs[i].meaddr;
      bus.tx_done_host = vecs[i].txd;
      bus.rd_valid_host = vecs[i].rdv;
      #1;
      ed = (vecs[i].edsel == 1) ? D_FE :
           (vecs[i].edsel == 2) ? D_ME : '0;
      chk_all($sformatf("v%0d", i), vecs[i].eop,
              vecs[i].eaddr, ed, vecs[i].efd,
              vecs[i].efv, vecs[i].emd, vecs[i].emv);
      next_cycle();
    end

    // reset in the middle of a fetch grant
    bus.Feop = 2'b01;
    bus.FeAddr = 32'h40;
    bus.Meop = 2'b00;
    bus.tx_done_host = 1'b0;
    bus.rd_valid_host = 1'b0;
    next_cycle();
    chk("rst_mid granted", 512'(bus.op_host), 512'(2'b01));
    bus.Meop = 2'b01;
    bus.MeAddr = 32'h50;
    bus.tx_done_host = 1'b1;
    bus.rd_valid_host = 1'b1;
    rst = 1'b1;
    #1;
    chk_all("rst_mid", 2'b00, 32'h0, '0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    bus.tx_done_host = 1'b0;
    bus.rd_valid_host = 1'b0;
    #1;
    chk("post_rst idle", 512'(bus.op_host), 512'(2'b00));
    next_cycle();
    // pointer was fetch before reset; reset makes fetch win again
    chk("post_rst fe op", 512'(bus.op_host), 512'(2'b01));
    chk("post_rst fe addr", 512'(bus.AddrOut_host), 512'(32'h40));
    bus.tx_done_host = 1'b1;
    #1;
    chk("post_rst fe done", 512'(bus.Fetx_done), 512'(1'b1));
    chk("post_rst me done", 512'(bus.Metx_done), 512'(1'b0));
    next_cycle();
    bus.Feop = 2'b00;
    bus.tx_done_host = 1'b0;
    #1;
    chk("post_rst gap", 512'(bus.op_host), 512'(2'b00));
    next_cycle();
    chk("post_rst me op", 512'(bus.op_host), 512'(2'b01));
    chk("post_rst me addr", 512'(bus.AddrOut_host), 512'(32'h50));
    bus.Meop = 2'b00;
    bus.tx_done_host = 1'b1;
    #1;
    chk("post_rst me done", 512'(bus.Metx_done), 512'(1'b1));
    next_cycle();
    bus.tx_done_host = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (single clock domain, all state on rising edge).
REQ-002 SHALL have: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have fetch requester ports: Feop  in  2  request op; FeAddr  in  32  byte address; FeDataOut  in  512  write line.
REQ-004 SHALL have fetch return ports: FeDataIn  out  512  read line; Fetx_done  out  1  transaction complete; Ferd_valid  out  1  read data valid.
REQ-005 SHALL have memory-stage ports, same widths and meanings: Meop in 2, MeAddr in 32, MeDataOut in 512, MeDataIn out 512, Metx_done out 1, Merd_valid out 1.
REQ-006 SHALL have host ports: op_host out 2, AddrOut_host out 32, DataOut_host out 512, DataIn_host in 512, tx_done_host in 1, rd_valid_host in 1.
REQ-007 SHALL use op encoding: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved (treated as idle, never granted).

Function
REQ-008 SHALL implement FSM states IDLE, GNT_FE, GNT_ME.
REQ-009 In IDLE, a requester is pending when its op is 01 or 10.
REQ-010 Only fetch pending in IDLE -> GNT_FE next cycle; only memory pending -> GNT_ME.
REQ-011 Both pending -> round-robin: grant the requester not served last; 1-bit pointer last_gnt updates on each grant.
REQ-012 On grant edge, SHALL capture winner's op, addr and 512-bit data into internal registers; later requester input changes ignored until release.
REQ-013 In GNT_FE/GNT_ME, op_host, AddrOut_host, DataOut_host SHALL drive captured registers, held stable until tx_done_host.
REQ-014 In IDLE, op_host SHALL be 00; AddrOut_host and DataOut_host SHALL be 0.
REQ-015 Latency: request seen in IDLE at cycle N -> op_host valid at cycle N+1.
REQ-016 Granted requester's tx_done and rd_valid SHALL equal tx_done_host and rd_valid_host combinationally, same cycle; non-granted requester's outputs SHALL be 0.
REQ-017 Granted requester's DataIn SHALL equal DataIn_host when rd_valid_host=1 and granted op is read, else 0; non-granted DataIn = 0.
REQ-018 rd_valid_host during a granted write SHALL be ignored (not forwarded).
REQ-019 tx_done_host=1 in a grant state -> IDLE next cycle; op_host = 00 for at least one cycle between transactions.
REQ-020 tx_done_host or rd_valid_host while IDLE SHALL be ignored; no output asserted.
REQ-021 Requester SHALL deassert op the cycle after its tx_done; op still asserted in IDLE counts as a new request.
REQ-022 No timeout: grant held indefinitely until tx_done_host.
REQ-023 With round-robin, a continuously requesting port SHALL wait at most one other transaction.

Reset
REQ-024 rst=1 at any time, including mid-transaction, SHALL force IDLE immediately; in-flight transaction abandoned, not replayed.
REQ-025 Reset values: op_host 00, AddrOut_host 0, DataOut_host 0, all Fe*/Me* outputs 0, captured registers 0.
REQ-026 Reset SHALL set last_gnt = memory, so fetch wins the first simultaneous request.
REQ-027 First grant possible on the first rising edge after rst deasserts.

Verification
REQ-028 Fetch-only read: Feop=01, FeAddr=0x0000_1000; host returns tx_done+rd_valid with DataIn_host=512'hA5... after 3 cycles -> op_host=01 at N+1, AddrOut_host=0x1000, FeDataIn=A5 pattern, Fetx_done=Ferd_valid=1 same cycle; Me outputs 0.
REQ-029 Simultaneous after reset: Feop=01, Meop=10 (MeAddr=0x2000) -> fetch granted first; after its tx_done, one idle cycle, then op_host=10, AddrOut_host=0x2000, DataOut_host=MeDataOut.
REQ-030 Fairness: both request continuously for 4 transactions -> grant order FE, ME, FE, ME.
REQ-031 Stability: during GNT_ME change MeAddr to 0x3000 -> AddrOut_host stays 0x2000 until tx_done_host.
REQ-032 Reset mid-op: rst=1 while GNT_FE with op_host=01 -> same-edge-independent return to op_host=00, all outputs 0; after release, pending Meop=01 granted with fetch-first pointer reset.
REQ-033 Spurious host: tx_done_host=1 and rd_valid_host=1 in IDLE, and rd_valid_host=1 during a write -> no Fe/Me done/valid asserted except the write's tx_done.
